// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle main control unit: state codes,
// opcodes, ALU operation codes, datapath mux selects and the control vector.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DEC_WAIT  = 4'd2,
        S_DECODE    = 4'd3,
        S_EXEC_R    = 4'd4,
        S_EXEC_I    = 4'd5,
        S_ALU_WB    = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_LUI_WB    = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    localparam logic [2:0] OP_RALU   = 3'b000;
    localparam logic [2:0] OP_IALU   = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_JAL    = 3'b101;
    localparam logic [2:0] OP_LUI    = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_PASSB = 4'hF;

    localparam logic [1:0] M2R_ALUOUT   = 2'd0;
    localparam logic [1:0] M2R_MDR      = 2'd1;
    localparam logic [1:0] M2R_PC       = 2'd2;
    localparam logic [1:0] SRCB_REGB    = 2'd0;
    localparam logic [1:0] SRCB_CONST2  = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Pure state-to-control decoder. Only the branch condition looks at ALU_Zero;
// func4 comes from a copy registered at dispatch, never from the live IR.
module control_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  state_t               i_state,
    input  logic [3:0]           i_func4,
    input  logic                 i_alu_zero,
    output ctrl_t                o_ctrl,
    output logic [ALUOP_W-1:0]   o_aluop
);

    always_comb begin
        o_ctrl  = '0;
        o_aluop = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ir_write = 1'b1;
                o_ctrl.alusrcb  = SRCB_CONST2;
                o_ctrl.pcsource = PCSRC_ALU;
                o_ctrl.pc_write = 1'b1;
                o_aluop         = ALUOP_W'(ALU_ADD);
            end
            S_DECODE: begin
                o_ctrl.alusrcb = SRCB_IMM;
                o_aluop        = ALUOP_W'(ALU_ADD);
            end
            S_EXEC_R: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_REGB;
                o_aluop        = ALUOP_W'(i_func4);
            end
            S_EXEC_I: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
                o_aluop        = ALUOP_W'(i_func4);
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.memtoreg  = M2R_ALUOUT;
            end
            S_MEM_ADDR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
                o_aluop        = ALUOP_W'(ALU_ADD);
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.memtoreg  = M2R_MDR;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_BRANCH: begin
                // func4[0] selects bne, which simply inverts the zero test
                o_ctrl.alusrca       = 1'b1;
                o_ctrl.alusrcb       = SRCB_REGB;
                o_ctrl.pcsource      = PCSRC_ALUOUT;
                o_ctrl.pc_write_cond = i_alu_zero ^ i_func4[0];
                o_aluop              = ALUOP_W'(ALU_SUB);
            end
            S_JUMP: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.memtoreg  = M2R_PC;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pcsource  = PCSRC_JUMP;
            end
            S_LUI_WB: begin
                o_ctrl.alusrcb   = SRCB_IMM;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.memtoreg  = M2R_ALUOUT;
                o_aluop          = ALUOP_W'(ALU_PASSB);
            end
            S_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: begin
                o_ctrl  = '0;
                o_aluop = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle main control unit: state register and next-state logic only;
// all datapath controls come from control_decode.
module control_unit_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [6:0]         i_ir_control,
    input  logic               i_alu_zero,
    output logic               o_pc_write,
    output logic               o_pc_write_cond,
    output logic               o_ir_write,
    output logic               o_iord,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_reg_write,
    output logic [1:0]         o_memtoreg,
    output logic               o_alusrca,
    output logic [1:0]         o_alusrcb,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic [1:0]         o_pcsource,
    output logic               o_halted,
    output logic [3:0]         o_state
);

    state_t     r_state;
    logic [3:0] r_func4;
    ctrl_t      w_ctrl;

    wire [2:0] w_opcode = i_ir_control[2:0];

    // func4 is captured at dispatch so later IR changes cannot reach the outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RESET;
            r_func4 <= '0;
        end else begin
            case (r_state)
                S_RESET:    r_state <= S_FETCH;
                S_FETCH:    r_state <= S_DEC_WAIT;
                S_DEC_WAIT: r_state <= S_DECODE;
                S_DECODE: begin
                    r_func4 <= i_ir_control[6:3];
                    case (w_opcode)
                        OP_RALU:   r_state <= S_EXEC_R;
                        OP_IALU:   r_state <= S_EXEC_I;
                        OP_LOAD,
                        OP_STORE:  r_state <= S_MEM_ADDR;
                        OP_BRANCH: r_state <= S_BRANCH;
                        OP_JAL:    r_state <= S_JUMP;
                        OP_LUI:    r_state <= S_LUI_WB;
                        default:   r_state <= S_HALT;
                    endcase
                end
                S_EXEC_R,
                S_EXEC_I:   r_state <= S_ALU_WB;
                S_MEM_ADDR: r_state <= (w_opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: r_state <= S_MEM_WB;
                S_ALU_WB,
                S_MEM_WB,
                S_MEM_WRITE,
                S_BRANCH,
                S_JUMP,
                S_LUI_WB:   r_state <= S_FETCH;
                S_HALT:     r_state <= S_HALT;
                default:    r_state <= S_RESET;
            endcase
        end
    end

    control_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_state    (r_state),
        .i_func4    (r_func4),
        .i_alu_zero (i_alu_zero),
        .o_ctrl     (w_ctrl),
        .o_aluop    (o_aluop)
    );

    assign o_pc_write      = w_ctrl.pc_write;
    assign o_pc_write_cond = w_ctrl.pc_write_cond;
    assign o_ir_write      = w_ctrl.ir_write;
    assign o_iord          = w_ctrl.iord;
    assign o_mem_read      = w_ctrl.mem_read;
    assign o_mem_write     = w_ctrl.mem_write;
    assign o_reg_write     = w_ctrl.reg_write;
    assign o_memtoreg      = w_ctrl.memtoreg;
    assign o_alusrca       = w_ctrl.alusrca;
    assign o_alusrcb       = w_ctrl.alusrcb;
    assign o_pcsource      = w_ctrl.pcsource;
    assign o_halted        = w_ctrl.halted;
    assign o_state         = r_state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized bench for control_unit_fsm against an instruction-level reference
// model: per-opcode state walks and per-step control values.
module tb_control_unit_fsm;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] ir  = '0;
    logic       zero = 1'b0;

    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] memtoreg, alusrcb, pcsource;
    logic       alusrca, halted;
    logic [3:0] aluop, state;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit_fsm #(.ALUOP_W(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ir_control    (ir),
        .i_alu_zero      (zero),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_ir_write      (ir_write),
        .o_iord          (iord),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_reg_write     (reg_write),
        .o_memtoreg      (memtoreg),
        .o_alusrca       (alusrca),
        .o_alusrcb       (alusrcb),
        .o_aluop         (aluop),
        .o_pcsource      (pcsource),
        .o_halted        (halted),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    wire [18:0] obs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                       reg_write, memtoreg, alusrca, alusrcb, aluop, pcsource, halted};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control values for one step of an instruction, from the operation table.
    function automatic logic [18:0] model_out(input state_t s, input logic [3:0] f4, input logic z);
        logic pcw, pcc, irw, ad, mr, mw, rw, sa, h;
        logic [1:0] m2r, sb, pcs;
        logic [3:0] op;
        {pcw, pcc, irw, ad, mr, mw, rw, sa, h} = '0;
        {m2r, sb, pcs} = '0;
        op = '0;
        case (s)
            S_FETCH:     begin mr = 1; irw = 1; sb = 2'd1; op = ALU_ADD; pcw = 1; end
            S_DECODE:    begin sb = 2'd2; op = ALU_ADD; end
            S_EXEC_R:    begin sa = 1; sb = 2'd0; op = f4; end
            S_EXEC_I:    begin sa = 1; sb = 2'd2; op = f4; end
            S_ALU_WB:    begin rw = 1; m2r = 2'd0; end
            S_MEM_ADDR:  begin sa = 1; sb = 2'd2; op = ALU_ADD; end
            S_MEM_READ:  begin mr = 1; ad = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 2'd1; end
            S_MEM_WRITE: begin mw = 1; ad = 1; end
            S_BRANCH:    begin sa = 1; op = ALU_SUB; pcs = 2'd1; pcc = f4[0] ? !z : z; end
            S_JUMP:      begin rw = 1; m2r = 2'd2; pcw = 1; pcs = 2'd2; end
            S_LUI_WB:    begin sb = 2'd2; op = ALU_PASSB; rw = 1; end
            S_HALT:      h = 1;
            default:     ;
        endcase
        return {pcw, pcc, irw, ad, mr, mw, rw, m2r, sa, sb, op, pcs, h};
    endfunction

    // Walks one instruction; ncyc<0 runs it fully, zf<0 randomizes ALU_Zero.
    task automatic run_instr(input logic [2:0] opc, input logic [3:0] f4, input int ncyc, input int zf);
        state_t seq[$];
        seq = '{S_FETCH, S_DEC_WAIT, S_DECODE};
        case (opc)
            OP_RALU:   begin seq.push_back(S_EXEC_R); seq.push_back(S_ALU_WB); end
            OP_IALU:   begin seq.push_back(S_EXEC_I); seq.push_back(S_ALU_WB); end
            OP_LOAD:   begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_READ); seq.push_back(S_MEM_WB); end
            OP_STORE:  begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WRITE); end
            OP_BRANCH: seq.push_back(S_BRANCH);
            OP_JAL:    seq.push_back(S_JUMP);
            OP_LUI:    seq.push_back(S_LUI_WB);
            default:   for (int k = 0; k < 20; k++) seq.push_back(S_HALT);
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (ncyc >= 0 && i >= ncyc) break;
            @(negedge clk);
            if (seq[i] == S_DECODE || seq[i] == S_MEM_ADDR) ir = {f4, opc};
            else ir = 7'($urandom);
            zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            #1;
            chk($sformatf("state_op%0d_step%0d", opc, i), 32'(state), 32'(seq[i]));
            chk($sformatf("ctrl_%s_op%0d", seq[i].name(), opc), 32'(obs),
                32'(model_out(seq[i], f4, zero)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'(S_RESET));
        chk("reset_ctrl", 32'(obs), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_release_state", 32'(state), 32'(S_RESET));
    endtask

    initial begin
        do_reset();

        for (int n = 0; n < 60; n++)
            run_instr(3'($urandom_range(0, 6)), 4'($urandom), -1, -1);

        for (int b = 0; b < 4; b++)
            run_instr(OP_BRANCH, {3'($urandom), 1'(b[1])}, -1, b & 1);

        run_instr(OP_STORE, 4'($urandom), 5, -1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_write", 32'(mem_write), 32'd0);
        chk("async_rst_state", 32'(state), 32'(S_RESET));
        chk("async_rst_ctrl", 32'(obs), 32'd0);
        do_reset();

        for (int n = 0; n < 10; n++)
            run_instr(3'($urandom_range(0, 6)), 4'($urandom), -1, -1);

        run_instr(OP_HALT, 4'($urandom), -1, -1);
        do_reset();
        run_instr(OP_LOAD, 4'($urandom), -1, -1);
        run_instr(OP_RALU, 4'h0, -1, -1);
        @(negedge clk);
        #1;
        chk("final_fetch", 32'(state), 32'(S_FETCH));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
